mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
- Bus responder on the opposite end of the p18240 system bus from the datapath.
- Decodes the datapath's memory address and the active-low read/write strobes.
- Serves word-wide reads and writes to an internal RAM and a small bank of memory-mapped I/O registers: LED output, synchronized switch input, auto-reload timer, and status.
- Drives the shared tri-state data bus only while it is answering a read.

Parameters:
- RAM_WORDS, 1024, number of 16-bit RAM words, mapped at addresses 0 .. RAM_WORDS-1 (power of two, at most 32768).
- IO_BASE, 16'hFF00, base address of the I/O register bank (8-word aligned).
- UNMAPPED_DATA, 16'hDEAD, value returned for reads of unmapped addresses.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset_L, input, 1, asynchronous active-low reset.
- memAddr, input, 16, word address from the datapath MAR.
- dataBus, inout, 16, shared data bus; driven here only during a valid read.
- re_L, input, 1, read strobe, active low.
- we_L, input, 1, write strobe, active low; write data is valid on dataBus.
- switchIn, input, 16, asynchronous external switches.
- ledOut, output, 16, LED register contents.
- timerIrq, output, 1, copy of STATUS bit 0 (timer match flag).

Behaviour:
- Valid read: re_L=0 and we_L=1. Valid write: we_L=0 and re_L=1. Both low is a bus conflict.
- Read path is combinational in the same cycle (zero wait states), because the datapath captures MDR at the clock edge that ends the read state.
- dataBus is driven only on a valid read; otherwise it is high-Z, including during a conflict.
- Writes commit at the rising edge that ends the write cycle.
- Address map:
  - RAM: addr < RAM_WORDS. Asynchronous read; synchronous write. RAM contents are not reset.
  - IO_BASE+0, LED (R/W): drives ledOut.
  - IO_BASE+2, SWITCH (RO): switchIn passed through a 2-flop synchronizer, so 2-cycle latency. Writes are ignored.
  - IO_BASE+4, TCOUNT (R/W): timer count.
  - IO_BASE+5, TCMP (R/W): timer compare value.
  - IO_BASE+6, STATUS:
    - bit0 = match flag (sticky).
    - bit1 = bus-error flag (sticky).
    - bit2 = timer enable.
    - Bits 15:3 read as 0.
  - Any other address: reads return UNMAPPED_DATA; writes are ignored.
- Timer, evaluated each cycle while enable=1:
  - If TCOUNT==TCMP: set the match flag and load TCOUNT to 0 (auto-reload).
  - Otherwise TCOUNT increments by 1, wrapping mod 2^16.
  - While enable=0, TCOUNT holds.
- Priority and simultaneous events:
  - A bus write to TCOUNT overrides increment/reload in the same cycle. A match against the old value still sets the flag.
  - Reading STATUS clears bits 0 and 1 at the end of that read cycle. The read returns the pre-clear value.
  - A set event in the same cycle as a clearing read wins; the flag stays 1.
  - Writing STATUS loads bit2 from data bit 2 only; bits 0 and 1 are unaffected by writes.
- Bus conflict: no RAM or register write occurs, the bus is not driven, and the bus-error flag is set at the clock edge.
- Reset, asynchronous, at any time including mid-cycle:
  - ledOut=0, TCOUNT=0, TCMP=16'hFFFF, enable=0, both flags=0, timerIrq=0, synchronizer flops=0.
  - dataBus is released immediately.
  - A write in progress when reset asserts is discarded.
- All arithmetic is 16-bit unsigned. RAM index is memAddr[log2(RAM_WORDS)-1:0], qualified by the upper bits being zero.

Test Plan:
- Reset, then write 16'h1234 to RAM addr 16'h0010 (we_L pulse), then read 16'h0010 with re_L=0 → dataBus=16'h1234 in the same cycle; with re_L=1 dataBus=Z.
- Write 16'h00A5 to IO_BASE+0 → ledOut=16'h00A5 after that edge; read IO_BASE+3 → 16'hDEAD; write 16'h5555 to IO_BASE+3 → no state changes.
- Set switchIn=16'hBEEF at edge N → SWITCH read returns 16'hBEEF from edge N+2 onward, and the old value before that.
- Write TCMP=3, then STATUS=16'h0004 → TCOUNT reads 1,2,3 on successive cycles, then 0; the match flag and timerIrq rise at the edge where 3→0. A STATUS read returns 16'h0005 and afterwards reads 16'h0004, unless a new match occurs in that same cycle.
- Drive re_L=0 and we_L=0 at RAM addr 16'h0010 with bus data 16'hFFFF → RAM still holds 16'h1234, dataBus not driven by the block, STATUS bit1=1 afterwards.
- Assert reset_L=0 mid-way through a timer run and while a read is driving the bus → bus goes Z immediately, ledOut=0, TCOUNT=0, TCMP=16'hFFFF, timerIrq=0.

Source files
------------

// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Bus responder for the p18240 system bus. It decodes the datapath's word
//   address and its active-low strobes. It serves reads and writes to an
//   internal RAM and to a small bank of memory-mapped I/O registers.
//
//   Ports:
//     clock     - system clock, rising-edge active
//     reset_L   - asynchronous active-low reset
//     memAddr   - 16-bit word address from the datapath MAR
//     dataBus   - shared 16-bit tri-state data bus (driven only on a valid read)
//     re_L      - read strobe, active low
//     we_L      - write strobe, active low (write data valid on dataBus)
//     switchIn  - asynchronous external switches
//     ledOut    - LED register contents
//     timerIrq  - timer match flag (STATUS bit 0)
//
//   I/O map (offsets from IO_BASE):
//     +0 LED (R/W), +2 SWITCH (RO, 2-flop synchronized), +4 TCOUNT (R/W),
//     +5 TCMP (R/W), +6 STATUS {13'b0, enable, bus_error, match}.
module mem_bus_responder #(
  parameter int unsigned  RAM_WORDS     = 1024,
  parameter logic [15:0]  IO_BASE       = 16'hFF00,
  parameter logic [15:0]  UNMAPPED_DATA = 16'hDEAD
) (
  input  logic        clock,
  input  logic        reset_L,
  input  logic [15:0] memAddr,
  inout  wire  [15:0] dataBus,
  input  logic        re_L,
  input  logic        we_L,
  input  logic [15:0] switchIn,
  output logic [15:0] ledOut,
  output logic        timerIrq
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [2:0] REG_LED    = 3'd0;
  localparam logic [2:0] REG_SWITCH = 3'd2;
  localparam logic [2:0] REG_TCOUNT = 3'd4;
  localparam logic [2:0] REG_TCMP   = 3'd5;
  localparam logic [2:0] REG_STATUS = 3'd6;

  // Bus cycle classification
  logic w_rd;
  logic w_wr;
  logic w_conflict;

  // Address decode
  logic          w_ram_sel;
  logic [AW-1:0] w_ram_idx;
  logic          w_io_sel;
  logic [2:0]    w_io_reg;

  logic        w_wr_tcount;
  logic        w_rd_status;
  logic        w_match;
  logic [15:0] w_rdata;
  logic [15:0] w_status;

  // State
  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_led;
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;
  logic [15:0] r_tcount;
  logic [15:0] r_tcmp;
  logic        r_en;
  logic        r_match;
  logic        r_berr;

  assign w_rd       = !re_L &&  we_L;
  assign w_wr       =  re_L && !we_L;
  assign w_conflict = !re_L && !we_L;

  // RAM occupies 0 .. RAM_WORDS-1: every address bit above the index must be 0.
  assign w_ram_sel = ((memAddr >> AW) == 16'd0);
  assign w_ram_idx = memAddr[AW-1:0];
  assign w_io_sel  = (memAddr[15:3] == IO_BASE[15:3]);
  assign w_io_reg  = memAddr[2:0];

  assign w_wr_tcount = w_wr && w_io_sel && (w_io_reg == REG_TCOUNT);
  assign w_rd_status = w_rd && w_io_sel && (w_io_reg == REG_STATUS);

  // Compare uses the registered count/compare values, so a same-cycle bus
  // write to either register cannot suppress a match on the old values.
  assign w_match = r_en && (r_tcount == r_tcmp);

  assign w_status = {13'd0, r_en, r_berr, r_match};

  // Zero-wait-state read path: the datapath latches MDR at the edge that
  // ends the read state, so this must settle within the same cycle.
  always_comb begin
    w_rdata = UNMAPPED_DATA;
    if (w_ram_sel) begin
      w_rdata = r_ram[w_ram_idx];
    end else if (w_io_sel) begin
      case (w_io_reg)
        REG_LED:    w_rdata = r_led;
        REG_SWITCH: w_rdata = r_sync2;
        REG_TCOUNT: w_rdata = r_tcount;
        REG_TCMP:   w_rdata = r_tcmp;
        REG_STATUS: w_rdata = w_status;
        default:    w_rdata = UNMAPPED_DATA;
      endcase
    end
  end

  // reset_L gates the driver so the bus is released the instant reset asserts.
  assign dataBus = (reset_L && w_rd) ? w_rdata : 16'bz;

  // RAM has no reset; reset_L gating discards a write caught by reset.
  always_ff @(posedge clock) begin
    if (reset_L && w_wr && w_ram_sel) begin
      r_ram[w_ram_idx] <= dataBus;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_led    <= '0;
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_tcount <= '0;
      r_tcmp   <= '1;
      r_en     <= 1'b0;
      r_match  <= 1'b0;
      r_berr   <= 1'b0;
    end else begin
      r_sync1 <= switchIn;
      r_sync2 <= r_sync1;

      if (w_wr && w_io_sel) begin
        case (w_io_reg)
          REG_LED:    r_led  <= dataBus;
          REG_TCMP:   r_tcmp <= dataBus;
          REG_STATUS: r_en   <= dataBus[2];
          default:    ;
        endcase
      end

      // Bus write beats the timer's own increment/reload.
      if (w_wr_tcount) begin
        r_tcount <= dataBus;
      end else if (r_en) begin
        r_tcount <= w_match ? '0 : r_tcount + 16'd1;
      end

      // Sticky flags: a set event in the same cycle as a clearing read wins.
      if (w_match) begin
        r_match <= 1'b1;
      end else if (w_rd_status) begin
        r_match <= 1'b0;
      end

      if (w_conflict) begin
        r_berr <= 1'b1;
      end else if (w_rd_status) begin
        r_berr <= 1'b0;
      end
    end
  end

  assign ledOut   = r_led;
  assign timerIrq = r_match;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Testbench for mem_bus_responder: directed steps followed by a randomized
// run, checked against a behavioural model of the responder's memory map.
module tb_mem_bus_responder;

  localparam int unsigned RAM_WORDS = 1024;
  localparam logic [15:0] IO_BASE   = 16'hFF00;
  localparam logic [15:0] UNM       = 16'hDEAD;

  localparam logic [15:0] A_LED    = IO_BASE;
  localparam logic [15:0] A_SWITCH = IO_BASE + 16'd2;
  localparam logic [15:0] A_HOLE   = IO_BASE + 16'd3;
  localparam logic [15:0] A_TCOUNT = IO_BASE + 16'd4;
  localparam logic [15:0] A_TCMP   = IO_BASE + 16'd5;
  localparam logic [15:0] A_STATUS = IO_BASE + 16'd6;

  logic        clock = 1'b0;
  logic        reset_L = 1'b1;
  logic [15:0] memAddr = '0;
  wire  [15:0] dataBus;
  logic        re_L = 1'b1;
  logic        we_L = 1'b1;
  logic [15:0] switchIn = '0;
  logic [15:0] ledOut;
  logic        timerIrq;

  logic        tb_oe = 1'b0;
  logic [15:0] tb_d  = '0;
  assign dataBus = tb_oe ? tb_d : 16'bz;

  mem_bus_responder #(
    .RAM_WORDS    (RAM_WORDS),
    .IO_BASE      (IO_BASE),
    .UNMAPPED_DATA(UNM)
  ) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .memAddr (memAddr),
    .dataBus (dataBus),
    .re_L    (re_L),
    .we_L    (we_L),
    .switchIn(switchIn),
    .ledOut  (ledOut),
    .timerIrq(timerIrq)
  );

  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Behavioural model of the address map
  logic [15:0] m_mem [int];
  logic [15:0] m_led, m_tcount, m_tcmp;
  bit          m_en, m_match, m_berr;
  logic [15:0] m_sw [$];   // switch samples from the last two edges; [0] is visible

  task automatic m_reset();
    m_led = '0; m_tcount = '0; m_tcmp = 16'hFFFF;
    m_en = 0; m_match = 0; m_berr = 0;
    m_sw.delete();
    m_sw.push_back(16'h0000);
    m_sw.push_back(16'h0000);
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (int'(a) < int'(RAM_WORDS)) return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 16'hxxxx;
    if (a == A_LED)    return m_led;
    if (a == A_SWITCH) return m_sw[0];
    if (a == A_TCOUNT) return m_tcount;
    if (a == A_TCMP)   return m_tcmp;
    if (a == A_STATUS) return {13'd0, m_en, m_berr, m_match};
    return UNM;
  endfunction

  task automatic m_edge(input bit re, input bit we, input logic [15:0] a, input logic [15:0] d);
    bit rd, wr, cf, hit;
    logic [15:0] nt;
    rd = !re && we;
    wr = re && !we;
    cf = !re && !we;
    hit = m_en && (m_tcount == m_tcmp);
    nt = m_en ? (hit ? 16'd0 : m_tcount + 16'd1) : m_tcount;
    if (wr) begin
      if (int'(a) < int'(RAM_WORDS)) m_mem[int'(a)] = d;
      else if (a == A_LED)    m_led = d;
      else if (a == A_TCOUNT) nt = d;
      else if (a == A_TCMP)   m_tcmp = d;
      else if (a == A_STATUS) m_en = d[2];
    end
    m_tcount = nt;
    if (rd && a == A_STATUS) begin
      m_match = 0;
      m_berr  = 0;
    end
    if (hit) m_match = 1;
    if (cf)  m_berr = 1;
    m_sw.push_back(switchIn);
    void'(m_sw.pop_front());
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Confirms the DUT is not driving: the bench's own pattern must come back intact.
  task automatic released(input string tag);
    tb_oe = 1'b1; tb_d = 16'h0000; #1;
    chk(tag, dataBus, 16'h0000);
    tb_d = 16'hFFFF; #1;
    chk(tag, dataBus, 16'hFFFF);
    tb_oe = 1'b0;
  endtask

  // One bus cycle, entered just after a rising edge, returning just after the next.
  task automatic cycle(input bit re, input bit we, input logic [15:0] a,
                       input logic [15:0] d, output logic [15:0] obs);
    re_L = re; we_L = we; memAddr = a;
    tb_oe = !we; tb_d = d;
    #2;
    obs = dataBus;
    if (!re && we) chk("read_data", dataBus, m_read(a));
    else if (!we)  chk("bus_not_driven", dataBus, d);
    @(posedge clock);
    m_edge(re, we, a, d);
    #1;
    chk("ledOut", ledOut, m_led);
    chk("timerIrq", {15'd0, timerIrq}, {15'd0, m_match});
    tb_oe = 1'b0; re_L = 1'b1; we_L = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] o;
    cycle(1'b1, 1'b0, a, d, o);
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] o);
    cycle(1'b0, 1'b1, a, 16'h0000, o);
  endtask

  task automatic rd_const(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] o;
    rd(a, o);
    chk(tag, o, exp);
  endtask

  logic [15:0] addr_tbl [14] = '{16'h0000, 16'h0010, 16'h0011, 16'h0200, 16'h03FF,
                                 A_LED, IO_BASE + 16'd1, A_SWITCH, A_HOLE, A_TCOUNT,
                                 A_TCMP, A_STATUS, 16'h0400, 16'h8000};

  initial begin
    logic [15:0] o, a, d;
    int unsigned r;

    // Reset
    #1 reset_L = 1'b0;
    m_reset();
    @(posedge clock); @(posedge clock); #1;
    chk("reset_ledOut", ledOut, 16'h0000);
    chk("reset_timerIrq", {15'd0, timerIrq}, 16'h0000);
    reset_L = 1'b1;

    // RAM write/read, including both ends of the RAM range
    wr(16'h0000, 16'h0F0F);
    wr(16'h0011, 16'h2222);
    wr(16'h0200, 16'h3333);
    wr(16'h03FF, 16'h4444);
    wr(16'h0010, 16'h1234);
    rd_const("ram_read", 16'h0010, 16'h1234);
    released("ram_no_read_released");
    rd_const("ram_last_word", 16'h03FF, 16'h4444);
    rd_const("ram_first_word", 16'h0000, 16'h0F0F);
    rd_const("above_ram_unmapped", 16'h0400, UNM);

    // LED and unmapped I/O hole
    wr(A_LED, 16'h00A5);
    chk("led_written", ledOut, 16'h00A5);
    rd_const("io_hole_read", A_HOLE, UNM);
    wr(A_HOLE, 16'h5555);
    rd_const("led_after_hole_write", A_LED, 16'h00A5);
    rd_const("status_after_hole_write", A_STATUS, 16'h0000);

    // Switch synchronizer latency
    switchIn = 16'hBEEF;
    rd_const("switch_before_e1", A_SWITCH, 16'h0000);
    rd_const("switch_after_e1", A_SWITCH, 16'h0000);
    rd_const("switch_after_e2", A_SWITCH, 16'hBEEF);
    wr(A_SWITCH, 16'h0000);
    rd_const("switch_write_ignored", A_SWITCH, 16'hBEEF);

    // Timer with auto-reload, sticky match flag, read-to-clear
    wr(A_TCMP, 16'd3);
    wr(A_STATUS, 16'h0004);
    rd_const("tcount_0", A_TCOUNT, 16'd0);
    rd_const("tcount_1", A_TCOUNT, 16'd1);
    rd_const("tcount_2", A_TCOUNT, 16'd2);
    chk("irq_before_match", {15'd0, timerIrq}, 16'h0000);
    rd_const("tcount_3", A_TCOUNT, 16'd3);
    chk("irq_at_match", {15'd0, timerIrq}, 16'h0001);
    rd_const("status_match", A_STATUS, 16'h0005);
    rd_const("status_cleared", A_STATUS, 16'h0004);
    cycle(1'b1, 1'b1, 16'h0000, 16'h0000, o);
    rd_const("status_read_during_match", A_STATUS, 16'h0004);
    rd_const("status_set_beats_clear", A_STATUS, 16'h0005);

    // Bus conflict on RAM
    cycle(1'b0, 1'b0, 16'h0010, 16'hFFFF, o);
    cycle(1'b0, 1'b0, 16'h0010, 16'h0000, o);
    rd_const("ram_after_conflict", 16'h0010, 16'h1234);
    rd(A_STATUS, o);
    chk("status_bus_error", {15'd0, o[1]}, 16'h0001);

    // Reset mid-timer while a read drives the bus; a write under reset is lost
    re_L = 1'b0; we_L = 1'b1; memAddr = A_LED;
    #1 chk("pre_reset_led_read", dataBus, 16'h00A5);
    #1 reset_L = 1'b0;
    m_reset();
    #1 released("reset_releases_bus");
    chk("reset_led_mid", ledOut, 16'h0000);
    chk("reset_irq_mid", {15'd0, timerIrq}, 16'h0000);
    re_L = 1'b1; we_L = 1'b0; memAddr = A_LED; tb_oe = 1'b1; tb_d = 16'h7777;
    @(posedge clock); #1;
    chk("write_under_reset_lost", ledOut, 16'h0000);
    tb_oe = 1'b0; we_L = 1'b1;
    reset_L = 1'b1;
    rd_const("reset_tcount", A_TCOUNT, 16'h0000);
    rd_const("reset_tcmp", A_TCMP, 16'hFFFF);
    rd_const("reset_status", A_STATUS, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) switchIn = 16'($urandom);
      a = addr_tbl[$urandom_range(0, 13)];
      d = 16'($urandom);
      if (a == A_TCOUNT || a == A_TCMP) d = 16'($urandom_range(0, 12));
      r = $urandom_range(0, 99);
      if (r < 45)      cycle(1'b0, 1'b1, a, d, o);
      else if (r < 80) cycle(1'b1, 1'b0, a, d, o);
      else if (r < 85) cycle(1'b0, 1'b0, a, d, o);
      else             cycle(1'b1, 1'b1, a, d, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
